// File: rtl/bts_pio_pkg.sv
// bts_pio_pkg: register map and edge-type encodings shared by the PIO block
// and its debounce slice.
package bts_pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_PERIOD  = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/bts_pio_debounce_bit.sv
// bts_pio_debounce_bit: one input bit -- two-flop synchroniser followed by a
// counter-based debouncer. With BTS_PIO_DEBOUNCE_EN undefined only the
// synchroniser remains and the output is the second sync flop.
module bts_pio_debounce_bit
`ifdef BTS_PIO_DEBOUNCE_EN
#(
  parameter int CNT_W = 16
)
`endif
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_async,
`ifdef BTS_PIO_DEBOUNCE_EN
  input  logic [CNT_W-1:0] i_period,
`endif
  output logic             o_stable
);

  logic r_sync1;
  logic r_sync2;

  // bring the board input into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
    end
  end

`ifdef BTS_PIO_DEBOUNCE_EN
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // accept a new level only once it has disagreed with stable for period+1 cycles;
  // >= lets a lowered period take effect on the very next cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt >= i_period) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;
`else
  assign o_stable = r_sync2;
`endif

endmodule

// File: rtl/bts_pio_in_irq.sv
// bts_pio_in_irq: Avalon-MM input PIO with per-bit synchroniser/debouncer,
// write-1-to-clear edge capture and a maskable level interrupt. Read latency 1.
// Build option: define BTS_PIO_DEBOUNCE_EN to include the debounce counters
// and the PERIOD register; otherwise address 1 reads 0.
module bts_pio_in_irq
  import bts_pio_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] PERIOD_RST = 16'd50000,
  parameter int               EDGE_TYPE  = 0
)
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rdata;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic             w_unused;

  // only the low bits of writedata land in registers
  assign w_unused = ^{writedata, PERIOD_RST};

`ifdef BTS_PIO_DEBOUNCE_EN
  logic [CNT_W-1:0] r_period;

  // debounce period register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= PERIOD_RST;
    end else if (write && address == ADDR_PERIOD) begin
      r_period <= writedata[CNT_W-1:0];
    end
  end
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    bts_pio_debounce_bit
`ifdef BTS_PIO_DEBOUNCE_EN
      #(.CNT_W(CNT_W))
`endif
      u_bit (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_async  (in_port[g]),
`ifdef BTS_PIO_DEBOUNCE_EN
        .i_period (r_period),
`endif
        .o_stable (w_stable[g])
      );
  end

  assign w_clr = (write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // edge selection on the debounced level against last cycle's level
  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      EDGE_RISE: w_edge = w_stable & ~r_prev;
      EDGE_FALL: w_edge = ~w_stable & r_prev;
      default:   w_edge = w_stable ^ r_prev;
    endcase
  end

  // mask register, edge capture (a new edge beats a same-cycle clear) and prev level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_prev    <= w_stable;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (write && address == ADDR_IRQMASK) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  // read mux; unused upper bits stay zero
  always_comb begin
    w_rdata = '0;
    case (address)
      ADDR_DATA:    w_rdata[WIDTH-1:0] = w_stable;
`ifdef BTS_PIO_DEBOUNCE_EN
      ADDR_PERIOD:  w_rdata[CNT_W-1:0] = r_period;
`endif
      ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
      default:      w_rdata = '0;
    endcase
  end

  // registered read data, one cycle after the address is sampled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rdata;
    end
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule
